// File: rtl/osc_rst_pkg.sv
// Shared definitions for the oscillator reset sequencer: FSM encoding,
// default timing constants derived from the 160 MHz clock, and counter sizing.
package osc_rst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int CLK_FREQ_HZ = 160_000_000;

    // 10 us of stable lock, 1 us between stages, 1 ms lock timeout
    localparam int DEF_LOCK_STABLE_CYCLES  = CLK_FREQ_HZ / 100_000;
    localparam int DEF_STAGE_GAP_CYCLES    = CLK_FREQ_HZ / 1_000_000;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000;

    function automatic int cnt_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/osc_reset_sequencer_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level input,
// cleared to 0 by a synchronous reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_chain;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[STAGES-2:0], d};
        end
    end

    assign q = sync_chain[STAGES-1];

endmodule

// File: rtl/osc_reset_sequencer.sv
// Qualifies init-done and PLL lock, then releases staged fabric resets in order;
// re-asserts everything on lock loss and keeps lock-fault status for readback.
module osc_reset_sequencer
    import osc_rst_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int N_STAGES            = 3,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int CNT_W               = cnt_width(DEF_LOCK_TIMEOUT_CYCLES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INIT_DONE,
    input  logic                PLL_LOCK,
    output logic [N_STAGES-1:0] STAGE_RESET,
    output logic                READY,
    output logic                LOCK_TIMEOUT,
    output logic [7:0]          RELOCK_COUNT,
    output logic [2:0]          STATE
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_nstages
        $error("N_STAGES must be in 1..8");
    end
    if (N_STAGES * STAGE_GAP_CYCLES >= (1 << CNT_W)) begin : g_bad_gap
        $error("N_STAGES*STAGE_GAP_CYCLES does not fit in CNT_W");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
        $error("LOCK_STABLE_CYCLES must be at least 1");
    end
    if (STAGE_GAP_CYCLES < 1) begin : g_bad_stage_gap
        $error("STAGE_GAP_CYCLES must be at least 1");
    end

    logic lock_s;
    logic init_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clock (CLK),
        .reset (RESET),
        .d     (PLL_LOCK),
        .q     (lock_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
        .clock (CLK),
        .reset (RESET),
        .d     (INIT_DONE),
        .q     (init_s)
    );

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_STAGES-1:0] stage_nxt;
    logic               ready_nxt;
    logic               timeout_nxt;
    logic [7:0]         relock_nxt;

    // State, counter and all outputs are registered together
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            STAGE_RESET  <= '1;
            READY        <= 1'b0;
            LOCK_TIMEOUT <= 1'b0;
            RELOCK_COUNT <= 8'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            STAGE_RESET  <= stage_nxt;
            READY        <= ready_nxt;
            LOCK_TIMEOUT <= timeout_nxt;
            RELOCK_COUNT <= relock_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stage_nxt   = STAGE_RESET;
        ready_nxt   = READY;
        timeout_nxt = LOCK_TIMEOUT;
        relock_nxt  = RELOCK_COUNT;

        case (state)
            ST_IDLE: begin
                stage_nxt = '1;
                ready_nxt = 1'b0;
                cnt_nxt   = '0;
                if (init_s) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    stage_nxt = '1;
                    ready_nxt = 1'b0;
                end else if (cnt == CNT_W'(N_STAGES * STAGE_GAP_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                stage_nxt = '0;
                ready_nxt = 1'b1;
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    stage_nxt = '1;
                    ready_nxt = 1'b0;
                    if (RELOCK_COUNT != 8'hFF) relock_nxt = RELOCK_COUNT + 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                stage_nxt = '1;
                ready_nxt = 1'b0;
            end
        endcase

        // Losing init-done outranks every lock event, including the relock count
        if (state != ST_IDLE && !init_s) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            stage_nxt  = '1;
            ready_nxt  = 1'b0;
            relock_nxt = RELOCK_COUNT;
        end

        // Stage k drops on the registered cycle where the release counter reads k*gap
        if (state_nxt == ST_RELEASE) begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (cnt_nxt == CNT_W'(k * STAGE_GAP_CYCLES)) stage_nxt[k] = 1'b0;
            end
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Directed testbench for osc_reset_sequencer using short timing parameters;
// expected cycle numbers are counted from the first edge after RESET drops.
module tb_osc_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       init_done;
    logic       pll_lock;
    logic [2:0] stage_reset;
    logic       ready;
    logic       lock_timeout;
    logic [7:0] relock_count;
    logic [2:0] state;

    int tests_run;
    int tests_failed;
    int cyc;

    osc_reset_sequencer #(
        .SYNC_STAGES         (2),
        .N_STAGES            (3),
        .LOCK_STABLE_CYCLES  (8),
        .STAGE_GAP_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .CNT_W               (8)
    ) dut (
        .CLK          (clk),
        .RESET        (reset),
        .INIT_DONE    (init_done),
        .PLL_LOCK     (pll_lock),
        .STAGE_RESET  (stage_reset),
        .READY        (ready),
        .LOCK_TIMEOUT (lock_timeout),
        .RELOCK_COUNT (relock_count),
        .STATE        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic apply_reset(input logic init_v, input logic lock_v);
        reset     = 1'b1;
        init_done = init_v;
        pll_lock  = lock_v;
        repeat (5) step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0, 1'b0);
        tests_run++;
        if (stage_reset !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL reset_stage: got %b expected %b", stage_reset, 3'b111);
        end
        tests_run++;
        if (ready !== 1'b0 || lock_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got ready=%b timeout=%b expected 0/0", ready, lock_timeout);
        end
        tests_run++;
        if (relock_count !== 8'd0 || state !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count_state: got count=%0d state=%0d expected 0/0", relock_count, state);
        end
    endtask

    task automatic test_nominal();
        apply_reset(1'b1, 1'b1);
        run_to(3);
        tests_run++;
        if (state !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL nominal_wait_lock: got state %0d expected 1", state);
        end
        run_to(4);
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL nominal_stable: got state %0d expected 2", state);
        end
        run_to(11);
        tests_run++;
        if (stage_reset !== 3'b111 || state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL nominal_pre_release: got stage %b state %0d expected 111/2", stage_reset, state);
        end
        run_to(12);
        tests_run++;
        if (stage_reset !== 3'b110 || state !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL nominal_stage0: got stage %b state %0d expected 110/3", stage_reset, state);
        end
        run_to(15);
        tests_run++;
        if (stage_reset !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL nominal_stage0_hold: got %b expected 110", stage_reset);
        end
        run_to(16);
        tests_run++;
        if (stage_reset !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL nominal_stage1: got %b expected 100", stage_reset);
        end
        run_to(20);
        tests_run++;
        if (stage_reset !== 3'b000 || ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL nominal_stage2: got stage %b ready %b expected 000/0", stage_reset, ready);
        end
        run_to(23);
        tests_run++;
        if (ready !== 1'b0 || state !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL nominal_pre_ready: got ready %b state %0d expected 0/3", ready, state);
        end
        run_to(24);
        tests_run++;
        if (ready !== 1'b1 || state !== 3'd4 || relock_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL nominal_run: got ready %b state %0d count %0d expected 1/4/0", ready, state, relock_count);
        end
    endtask

    task automatic test_lock_bounce();
        apply_reset(1'b1, 1'b1);
        run_to(8);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        run_to(10);
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL bounce_still_stable: got state %0d expected 2", state);
        end
        run_to(11);
        tests_run++;
        if (state !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL bounce_wait_lock: got state %0d expected 1", state);
        end
        run_to(12);
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL bounce_restable: got state %0d expected 2", state);
        end
        run_to(19);
        tests_run++;
        if (state !== 3'd2 || stage_reset !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL bounce_full_requalify: got state %0d stage %b expected 2/111", state, stage_reset);
        end
        run_to(20);
        tests_run++;
        if (state !== 3'd3 || stage_reset !== 3'b110 || relock_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL bounce_release: got state %0d stage %b count %0d expected 3/110/0", state, stage_reset, relock_count);
        end
    endtask

    task automatic test_timeout();
        apply_reset(1'b1, 1'b0);
        run_to(34);
        tests_run++;
        if (lock_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: got %b expected 0", lock_timeout);
        end
        run_to(35);
        tests_run++;
        if (lock_timeout !== 1'b1 || state !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_set: got timeout %b state %0d expected 1/1", lock_timeout, state);
        end
        run_to(40);
        pll_lock = 1'b1;
        run_to(42);
        tests_run++;
        if (state !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_sync_lag: got state %0d expected 1", state);
        end
        run_to(43);
        tests_run++;
        if (state !== 3'd2 || lock_timeout !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_stable: got state %0d timeout %b expected 2/1", state, lock_timeout);
        end
        run_to(51);
        tests_run++;
        if (stage_reset !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL timeout_release: got %b expected 110", stage_reset);
        end
        run_to(63);
        tests_run++;
        if (ready !== 1'b1 || lock_timeout !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_sticky_run: got ready %b timeout %b expected 1/1", ready, lock_timeout);
        end
    endtask

    task automatic test_run_loss();
        int waited;
        apply_reset(1'b1, 1'b1);
        run_to(25);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        run_to(27);
        tests_run++;
        if (ready !== 1'b1 || stage_reset !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL loss_sync_lag: got ready %b stage %b expected 1/000", ready, stage_reset);
        end
        run_to(28);
        tests_run++;
        if (ready !== 1'b0 || stage_reset !== 3'b111 || relock_count !== 8'd1 || state !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL loss_reassert: got ready %b stage %b count %0d state %0d expected 0/111/1/1",
                     ready, stage_reset, relock_count, state);
        end
        run_to(29);
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL loss_restable: got state %0d expected 2", state);
        end
        run_to(37);
        tests_run++;
        if (stage_reset !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL loss_rerelease: got %b expected 110", stage_reset);
        end
        run_to(49);
        tests_run++;
        if (ready !== 1'b1 || stage_reset !== 3'b000 || relock_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL loss_rerun: got ready %b stage %b count %0d expected 1/000/1", ready, stage_reset, relock_count);
        end

        // 300 further losses from RUN: count must stop at 255
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            step();
            step();
            waited = 0;
            while (ready !== 1'b1 && waited < 40) begin
                step();
                waited++;
            end
            if (ready !== 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL loss_loop_ready: iteration %0d got ready %b expected 1 within 40 cycles", i, ready);
                break;
            end
        end
        tests_run++;
        if (relock_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL loss_saturate: got %0d expected 255", relock_count);
        end
    endtask

    task automatic test_init_drop();
        apply_reset(1'b1, 1'b1);
        run_to(16);
        tests_run++;
        if (stage_reset !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL init_mid_setup: got %b expected 100", stage_reset);
        end
        init_done = 1'b0;
        run_to(18);
        tests_run++;
        if (stage_reset !== 3'b100 || state !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL init_sync_lag: got stage %b state %0d expected 100/3", stage_reset, state);
        end
        run_to(19);
        tests_run++;
        if (stage_reset !== 3'b111 || state !== 3'd0 || relock_count !== 8'd0 || ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL init_abort: got stage %b state %0d count %0d ready %b expected 111/0/0/0",
                     stage_reset, state, relock_count, ready);
        end

        // Simultaneous init and lock loss in RUN: init wins, no relock counted
        apply_reset(1'b1, 1'b1);
        run_to(24);
        init_done = 1'b0;
        pll_lock  = 1'b0;
        run_to(27);
        tests_run++;
        if (state !== 3'd0 || relock_count !== 8'd0 || stage_reset !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL init_priority: got state %0d count %0d stage %b expected 0/0/111",
                     state, relock_count, stage_reset);
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset(1'b1, 1'b0);
        run_to(40);
        pll_lock = 1'b1;
        run_to(63);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        run_to(87);
        tests_run++;
        if (ready !== 1'b1 || lock_timeout !== 1'b1 || relock_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL rst_setup: got ready %b timeout %b count %0d expected 1/1/1", ready, lock_timeout, relock_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (stage_reset !== 3'b111 || ready !== 1'b0 || lock_timeout !== 1'b0 ||
            relock_count !== 8'd0 || state !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_run: got stage %b ready %b timeout %b count %0d state %0d expected 111/0/0/0/0",
                     stage_reset, ready, lock_timeout, relock_count, state);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset        = 1'b1;
        init_done    = 1'b0;
        pll_lock     = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_lock_bounce();
        test_timeout();
        test_run_loss();
        test_init_drop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
